// File: rtl/if_stage_hs_if.sv
// Fetch-stage bundle: decode-side handshake, redirect request and the
// instruction-memory load port, seen from the fetch stage as the slave.
interface if_stage_hs_if #(
    parameter int XLEN = 64
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            imem_we;
    logic [XLEN-1:0] imem_waddr;
    logic [31:0]     imem_wdata;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_fault;

    modport master (
        output redirect_valid, redirect_pc, id_ready,
        output imem_we, imem_waddr, imem_wdata,
        input  if_valid, if_pc, if_instr, if_fault
    );

    modport slave (
        input  redirect_valid, redirect_pc, id_ready,
        input  imem_we, imem_waddr, imem_wdata,
        output if_valid, if_pc, if_instr, if_fault
    );
endinterface

// File: rtl/if_stage_hs.sv
// Instruction-fetch stage: PC, word-indexed instruction memory with a load port,
// a registered valid/ready output to decode, redirect flush and fault halting.
module if_stage_hs #(
    parameter int              XLEN       = 64,
    parameter int              IMEM_DEPTH = 128,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         reset,
    if_stage_hs_if.slave bus
);
    localparam int IDX_W = $clog2(IMEM_DEPTH);
    localparam int HI_W  = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_r;
    logic [XLEN-1:0]  pc_r;
    logic [31:0]      mem_r [IMEM_DEPTH];

    logic             fault_s;
    logic             advance_s;
    logic             wr_ok_s;
    logic [IDX_W-1:0] rd_idx_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic             unused_waddr_lo_s;

    // Byte-offset bits of the write address carry no meaning for word writes.
    assign unused_waddr_lo_s = ^bus.imem_waddr[1:0];

    // Fetch fault detection, advance decision and memory index decode.
    always_comb begin
        fault_s   = 1'b0;
        advance_s = 1'b0;
        wr_ok_s   = 1'b0;
        rd_idx_s  = pc_r[IDX_W+1:2];
        wr_idx_s  = bus.imem_waddr[IDX_W+1:2];
        if ((pc_r[1:0] != 2'b00) || (pc_r[XLEN-1:IDX_W+2] != {HI_W{1'b0}})) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
        if ((state_r == ST_RUN) && !bus.redirect_valid && (!bus.if_valid || bus.id_ready)) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
        if (bus.imem_we && (bus.imem_waddr[XLEN-1:IDX_W+2] == {HI_W{1'b0}})) begin
            wr_ok_s = 1'b1;
        end else begin
            wr_ok_s = 1'b0;
        end
    end

    // Instruction memory load port; a same-cycle fetch still sees the old word.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_idx_s] <= bus.imem_wdata;
        end
    end

    // PC, run/halt state and the registered decode-side output entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            state_r      <= ST_RUN;
            bus.if_valid <= 1'b0;
            bus.if_pc    <= {XLEN{1'b0}};
            bus.if_instr <= NOP_INSTR;
            bus.if_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_r         <= bus.redirect_pc;
            state_r      <= ST_RUN;
            bus.if_valid <= 1'b0;
            bus.if_fault <= 1'b0;
        end else if (advance_s) begin
            bus.if_valid <= 1'b1;
            bus.if_pc    <= pc_r;
            if (fault_s) begin
                // Faulting PC is kept so the reported address stays stable in HALT.
                bus.if_instr <= NOP_INSTR;
                bus.if_fault <= 1'b1;
                state_r      <= ST_HALT;
            end else begin
                bus.if_instr <= mem_r[rd_idx_s];
                bus.if_fault <= 1'b0;
                pc_r         <= pc_r + PC_STEP;
            end
        end else if (bus.if_valid && bus.id_ready) begin
            bus.if_valid <= 1'b0;
        end else begin
            bus.if_valid <= bus.if_valid;
        end
    end
endmodule

// File: tb/tb_if_stage_hs.sv
// Directed bench for if_stage_hs: a cycle table of inputs and expected outputs,
// then hand sequences for the end-of-memory sweep and reset during stall/halt.
module tb_if_stage_hs;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        we;
        logic [63:0] wa;
        logic [31:0] wd;
        logic        ev;
        logic [63:0] epc;
        logic [31:0] ei;
        logic        ef;
    } vec_t;

    logic        clk;
    logic        reset;
    int          n_cmp;
    int          n_bad;
    logic [31:0] model [128];
    vec_t        tbl [$];

    if_stage_hs_if #(.XLEN(64)) bus ();

    if_stage_hs #(
        .XLEN(64), .IMEM_DEPTH(128), .RESET_PC(64'h0), .NOP_INSTR(32'h0000_0013)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [63:0] epc,
                             input logic [31:0] ei, input logic ef);
        check({tag, ".valid"}, {63'd0, bus.if_valid}, {63'd0, ev});
        check({tag, ".pc"},    bus.if_pc, epc);
        check({tag, ".instr"}, {32'd0, bus.if_instr}, {32'd0, ei});
        check({tag, ".fault"}, {63'd0, bus.if_fault}, {63'd0, ef});
    endtask

    task automatic step(input logic rv, input logic [63:0] rpc, input logic rdy,
                        input logic we, input logic [63:0] wa, input logic [31:0] wd);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.id_ready       = rdy;
        bus.imem_we        = we;
        bus.imem_waddr     = wa;
        bus.imem_wdata     = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);

        // Memory image: filler words, then the named test words.
        for (int i = 0; i < 128; i++) model[i] = 32'hD000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) model[i] = 32'hA0 + 32'(i);
        model[8] = 32'hB8;
        for (int i = 0; i < 128; i++) step(1'b0, 64'h0, 1'b0, 1'b1, 64'(4 * i), model[i]);
        step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        check_out("reset", 1'b0, 64'h0, NOP, 1'b0);
        reset = 1'b0;

        //                rv    rpc      rdy   we    wa       wd            ev    epc      ei             ef
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h0,   32'hA0,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h4,   32'hA1,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,  1'b1, 64'h4,   32'hA1,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,  1'b1, 64'h4,   32'hA1,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,  1'b1, 64'h4,   32'hA1,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h8,   32'hA2,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'hC,   32'hA3,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,  1'b1, 64'hC,   32'hA3,        1'b0});
        tbl.push_back('{1'b1, 64'h20,  1'b0, 1'b0, 64'h0,   32'h0,  1'b0, 64'hC,   32'hA3,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,  1'b1, 64'h20,  32'hB8,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h24,  32'hD000_0009, 1'b0});
        tbl.push_back('{1'b1, 64'h22,  1'b1, 1'b0, 64'h0,   32'h0,  1'b0, 64'h24,  32'hD000_0009, 1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,  1'b1, 64'h22,  NOP,           1'b1});
        tbl.push_back('{1'b0, 64'h0,   1'b0, 1'b0, 64'h0,   32'h0,  1'b1, 64'h22,  NOP,           1'b1});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b0, 64'h22,  NOP,           1'b1});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b0, 64'h22,  NOP,           1'b1});
        tbl.push_back('{1'b1, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b0, 64'h22,  NOP,           1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h0,   32'hA0,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h4,   32'hA1,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b1, 64'h8,   32'hC0, 1'b1, 64'h8,   32'hA2,        1'b0});
        tbl.push_back('{1'b1, 64'h8,   1'b1, 1'b0, 64'h0,   32'h0,  1'b0, 64'h8,   32'hA2,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h8,   32'hC0,        1'b0});
        tbl.push_back('{1'b1, 64'h0,   1'b1, 1'b1, 64'h200, 32'hEE, 1'b0, 64'h8,   32'hC0,        1'b0});
        tbl.push_back('{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   32'h0,  1'b1, 64'h0,   32'hA0,        1'b0});
        model[2] = 32'hC0;

        foreach (tbl[i]) begin
            step(tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wd);
            check_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei, tbl[i].ef);
        end

        // Sequential sweep to the last word, then the out-of-range fault and HALT.
        for (int i = 1; i < 128; i++) begin
            step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
            check_out($sformatf("sweep%0d", i), 1'b1, 64'(4 * i), model[i], 1'b0);
        end
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("end_fault", 1'b1, 64'h200, NOP, 1'b1);
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("end_halt1", 1'b0, 64'h200, NOP, 1'b1);
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("end_halt2", 1'b0, 64'h200, NOP, 1'b1);

        // Asynchronous reset in the middle of a stall.
        step(1'b1, 64'h4, 1'b0, 1'b0, 64'h0, 32'h0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        check_out("stall_pre", 1'b1, 64'h4, 32'hA1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 32'h0);
        #3 reset = 1'b1;
        #1 check_out("async_rst", 1'b0, 64'h0, NOP, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("restart0", 1'b1, 64'h0, 32'hA0, 1'b0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("restart1", 1'b1, 64'h4, 32'hA1, 1'b0);

        // Reset while halted on a misaligned fetch.
        step(1'b1, 64'h2, 1'b1, 1'b0, 64'h0, 32'h0);
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("mis_fault", 1'b1, 64'h2, NOP, 1'b1);
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("mis_halt", 1'b0, 64'h2, NOP, 1'b1);
        #2 reset = 1'b1;
        #1 check_out("halt_rst", 1'b0, 64'h0, NOP, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        step(1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0);
        check_out("halt_restart", 1'b1, 64'h0, 32'hA0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
